// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE-754 adder/subtractor with runtime rounding mode and valid/ready handshakes.
// Define FP_ADD_SUBNORM_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  input  logic [1:0]           rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int AW = MAN_W + 5;
  localparam int XW = EXP_W + $clog2(SW + 1) + 1;
  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state_reg, state_next;

  logic [W-1:0]          a_reg, b_reg, spec_res_reg, result_reg;
  logic                  op_reg, sign_reg, sub_reg, spec_reg, zero_reg;
  logic [1:0]            rnd_reg;
  logic [3:0]            spec_flags_reg, flags_reg;
  logic [SW-1:0]         sx_reg, sy_reg, nsig_reg;
  logic [AW-1:0]         acc_reg;
  logic signed [XW-1:0]  exp_reg;

  // Operand classification, swap and alignment
  logic                  sa, sb, sbe, a_nan, b_nan, a_inf, b_inf, a_ge, eff_sub, sign_x, spec;
  logic [EXP_W-1:0]      ea, eb, expa, expb, ex, ey, d;
  logic [MAN_W-1:0]      fa, fb;
  logic [MAN_W:0]        siga, sigb, sigx, sigy;
  logic [SW-1:0]         yext, y_mask, sy;
  logic [W-1:0]          spec_res;
  logic [3:0]            spec_flags;
  int unsigned           sh;

  assign {sa, ea, fa} = a_reg;
  assign {sb, eb, fb} = b_reg;

  always_comb begin
    sbe     = sb ^ op_reg;
    eff_sub = sa ^ sbe;
    a_nan   = (ea == '1) && (fa != '0);
    b_nan   = (eb == '1) && (fb != '0);
    a_inf   = (ea == '1) && (fa == '0);
    b_inf   = (eb == '1) && (fb == '0);
    expa    = (ea == '0) ? EXP_W'(1) : ea;
    expb    = (eb == '0) ? EXP_W'(1) : eb;
`ifdef FP_ADD_SUBNORM_EN
    siga    = {ea != '0, fa};
    sigb    = {eb != '0, fb};
`else
    siga    = (ea == '0) ? '0 : {1'b1, fa};
    sigb    = (eb == '0) ? '0 : {1'b1, fb};
`endif
    a_ge    = {expa, siga} >= {expb, sigb};
    ex      = a_ge ? expa : expb;
    ey      = a_ge ? expb : expa;
    sigx    = a_ge ? siga : sigb;
    sigy    = a_ge ? sigb : siga;
    sign_x  = a_ge ? sa : sbe;
    d       = ex - ey;
    sh      = (32'(d) > MAN_W + 3) ? MAN_W + 3 : 32'(d);
    yext    = {sigy, 3'b000};
    y_mask  = ~({SW{1'b1}} << sh);
    sy      = (yext >> sh) | {{(SW-1){1'b0}}, |(yext & y_mask)};

    spec       = a_nan | b_nan | a_inf | b_inf;
    spec_res   = QNAN;
    spec_flags = 4'b0000;
    if ((a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]) || (a_inf && b_inf && eff_sub))
      spec_flags = 4'b1000;
    else if (a_nan || b_nan)
      spec_res = QNAN;
    else if (a_inf)
      spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (b_inf)
      spec_res = {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic [AW-1:0] acc;
  assign acc = sub_reg ? ({1'b0, sx_reg} - {1'b0, sy_reg}) : ({1'b0, sx_reg} + {1'b0, sy_reg});

  // Normalisation: carry shift right, else leading-one shift left bounded by the exponent floor
  int                   lz, shl, shl_max;
  logic [SW-1:0]        nsig;
  logic signed [XW-1:0] nexp;
  logic                 nzero, nsign;

  always_comb begin
    lz = SW;
    for (int i = 0; i < SW; i++)
      if (acc_reg[i]) lz = SW - 1 - i;
`ifdef FP_ADD_SUBNORM_EN
    shl_max = int'(exp_reg) - 1;
`else
    shl_max = SW;
`endif
    shl   = (lz > shl_max) ? shl_max : lz;
    nzero = (acc_reg == '0);
    nsign = (nzero && sub_reg) ? (rnd_reg == RDN) : sign_reg;
    if (acc_reg[AW-1]) begin
      nsig = {acc_reg[AW-1:2], acc_reg[1] | acc_reg[0]};
      nexp = exp_reg + XW'(1);
    end else begin
      nsig = acc_reg[SW-1:0] << shl;
      nexp = exp_reg - XW'(shl);
    end
  end

  // Rounding, overflow/underflow handling and special-value override
  logic                 lsb, g, r, s, inexact, inc, hidden, to_inf, ovf, flush_uf, uflow;
  logic [MAN_W+1:0]     rsum;
  logic [MAN_W-1:0]     frac_out;
  logic signed [XW-1:0] rexp;
  logic [W-1:0]         fin_res;
  logic [3:0]           fin_flags;

  always_comb begin
    lsb     = nsig_reg[3];
    g       = nsig_reg[2];
    r       = nsig_reg[1];
    s       = nsig_reg[0];
    inexact = g | r | s;
    inc     = 1'b0;
    unique case (rnd_reg)
      RNE:     inc = g & (r | s | lsb);
      RTZ:     inc = 1'b0;
      RUP:     inc = !sign_reg & inexact;
      default: inc = sign_reg & inexact;
    endcase
    rsum     = {1'b0, nsig_reg[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    hidden   = rsum[MAN_W+1] | rsum[MAN_W];
    frac_out = rsum[MAN_W+1] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
    rexp     = exp_reg + XW'(rsum[MAN_W+1]);
    ovf      = int'(rexp) >= (1 << EXP_W) - 1;
    to_inf   = (rnd_reg == RNE) || (rnd_reg == RUP && !sign_reg) || (rnd_reg == RDN && sign_reg);
`ifdef FP_ADD_SUBNORM_EN
    flush_uf = 1'b0;
    uflow    = !nsig_reg[SW-1] & inexact;
`else
    flush_uf = int'(rexp) < 1;
    uflow    = 1'b0;
`endif
    fin_res   = {sign_reg, hidden ? rexp[EXP_W-1:0] : {EXP_W{1'b0}}, frac_out};
    fin_flags = {2'b00, uflow, inexact};
    if (spec_reg) begin
      fin_res   = spec_res_reg;
      fin_flags = spec_flags_reg;
    end else if (zero_reg) begin
      fin_res   = {sign_reg, {(W-1){1'b0}}};
      fin_flags = 4'b0000;
    end else if (ovf) begin
      fin_res   = to_inf ? {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      fin_flags = 4'b0101;
    end else if (flush_uf) begin
      fin_res   = {sign_reg, {(W-1){1'b0}}};
      fin_flags = 4'b0011;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (in_valid) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      default: if (out_ready) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        IDLE: if (in_valid) begin
          a_reg   <= a;
          b_reg   <= b;
          op_reg  <= op;
          rnd_reg <= rnd_mode;
        end
        ALIGN: begin
          sx_reg         <= {sigx, 3'b000};
          sy_reg         <= sy;
          exp_reg        <= XW'(ex);
          sign_reg       <= sign_x;
          sub_reg        <= eff_sub;
          spec_reg       <= spec;
          spec_res_reg   <= spec_res;
          spec_flags_reg <= spec_flags;
        end
        ADD:  acc_reg <= acc;
        NORM: begin
          nsig_reg <= nsig;
          exp_reg  <= nexp;
          sign_reg <= nsign;
          zero_reg <= nzero;
        end
        ROUND: begin
          result_reg <= fin_res;
          flags_reg  <= fin_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;
endmodule

// File: tb/tb_fp_addsub_param.sv
// Scoreboard bench for fp_addsub_param: directed vectors in single precision plus a half-precision instance.
// Expected results follow FP_ADD_SUBNORM_EN the same way the design does.
module tb_fp_addsub_param;
  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

  logic        clk, rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [1:0]  rnd_mode;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int txn = 0;
  bit prev_valid = 0;
  logic [35:0] exp_q[$];
  logic [19:0] h_q[$];

  fp_addsub_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_half (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b), .op(1'b0),
    .rnd_mode(RNE), .out_valid(h_out_valid), .out_ready(1'b1), .result(h_result), .flags(h_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: latency measured from the handshake cycle, results popped from the scoreboard
  always @(negedge clk) begin
    logic [35:0] e;
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'd5);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: result=%h flags=%b, required no output", result, flags);
        end else begin
          e = exp_q.pop_front();
          txn++;
          if ({result, flags} !== e) begin
            errors++;
            $display("FAIL txn%0d: result=%h flags=%b, required result=%h flags=%b",
                     txn, result, flags, e[35:4], e[3:0]);
          end else begin
            $display("txn %0d ok: result=%h flags=%b", txn, result, flags);
          end
        end
      end
      prev_valid = out_valid;
    end
    if (h_out_valid && !rst) begin
      checks++;
      if (h_q.size() == 0) begin
        errors++;
        $display("FAIL half_unexpected: result=%h, required no output", h_result);
      end else begin
        logic [19:0] he;
        he = h_q.pop_front();
        if ({h_result, h_flags} !== he) begin
          errors++;
          $display("FAIL half: result=%h flags=%b, required result=%h flags=%b", h_result, h_flags, he[19:4], he[3:0]);
        end else begin
          $display("half txn ok: result=%h flags=%b", h_result, h_flags);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb2, input logic top,
                       input logic [1:0] trnd, input logic [31:0] eres, input logic [3:0] eflg,
                       input bit expect_out);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 64'(in_ready), 64'd1);
      return;
    end
    a = ta; b = tb2; op = top; rnd_mode = trnd; in_valid = 1'b1;
    if (expect_out) exp_q.push_back({eres, eflg});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0 || !in_ready) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run(input logic [31:0] ta, input logic [31:0] tb2, input logic top,
                     input logic [1:0] trnd, input logic [31:0] eres, input logic [3:0] eflg);
    issue(ta, tb2, top, trnd, eres, eflg, 1'b1);
    drain();
  endtask

  task automatic run_half(input logic [15:0] ta, input logic [15:0] tb2, input logic [15:0] eres);
    int g = 0;
    h_a = ta; h_b = tb2; h_in_valid = 1'b1;
    h_q.push_back({eres, 4'b0000});
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    while ((h_q.size() != 0 || !h_in_ready) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (h_q.size() != 0 || !h_in_ready) chk("half_timeout", 64'(h_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0; rnd_mode = RNE;
    h_in_valid = 1'b0; h_a = '0; h_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, result, flags}, {1'b1, 1'b0, 32'h0, 4'h0});
    chk("reset_half", {h_in_ready, h_out_valid, h_result}, {1'b1, 1'b0, 16'h0});
    rst = 1'b0;
    @(posedge clk); #1;

    run(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 4'b0000);
    run(32'h3F800000, 32'h3F800000, 1'b1, RNE, 32'h00000000, 4'b0000);
    run(32'h3F800000, 32'h3F800000, 1'b1, RDN, 32'h80000000, 4'b0000);
    run(32'h7F800000, 32'hFF800000, 1'b0, RNE, 32'h7FC00000, 4'b1000);
    run(32'h7FC00001, 32'hFF800000, 1'b0, RNE, 32'h7FC00000, 4'b0000);
    run(32'h7F800001, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 4'b1000);
    run(32'h3F800000, 32'h7F800000, 1'b1, RNE, 32'hFF800000, 4'b0000);
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE, 32'h7F800000, 4'b0101);
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RTZ, 32'h7F7FFFFF, 4'b0101);
    run(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RUP, 32'hFF7FFFFF, 4'b0101);
    run(32'h3F800000, 32'h33800000, 1'b0, RNE, 32'h3F800000, 4'b0001);
    run(32'h3F800000, 32'h33800000, 1'b0, RUP, 32'h3F800001, 4'b0001);
    run(32'h40400000, 32'h3F800000, 1'b1, RNE, 32'h40000000, 4'b0000);
    run(32'h3F800000, 32'hBF800000, 1'b1, RNE, 32'h40000000, 4'b0000);
    run(32'h80000000, 32'h80000000, 1'b0, RNE, 32'h80000000, 4'b0000);
`ifdef FP_ADD_SUBNORM_EN
    run(32'h00000001, 32'h00000001, 1'b0, RNE, 32'h00000002, 4'b0000);
`else
    run(32'h00000001, 32'h00000001, 1'b0, RNE, 32'h00000000, 4'b0000);
`endif

    // Backpressure: result held for three DONE cycles, then a back-to-back accept
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 4'b0000, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_state", {out_valid, in_ready, result, flags}, {1'b1, 1'b0, 32'h40400000, 4'b0000});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    a = 32'h40400000; b = 32'h3F800000; op = 1'b1; rnd_mode = RNE; in_valid = 1'b1;
    exp_q.push_back({32'h40000000, 4'b0000});
    @(posedge clk); #1;
    chk("ready_after_handshake", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("back_to_back_accept", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    drain();

    // Reset while in NORM abandons the operation
    issue(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_mid_op", {in_ready, out_valid}, {1'b1, 1'b0});
    repeat (8) @(posedge clk);
    #1;
    chk("no_output_after_reset", 64'(out_valid), 64'd0);

    run_half(16'h3C00, 16'h3C00, 16'h4000);
    run_half(16'h3C00, 16'h4000, 16'h4200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
